// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared types and default constants for the memory stage
package arm_mem_pkg;

  // Memory-stage sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // Byte address of data-memory word 0 and word-address width on the bus
  localparam int unsigned MEM_BASE_DEF = 1024;
  localparam int unsigned ADDR_W_DEF   = 16;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with load and bubble controls
module mem_wb_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic        data_load,
  input  logic        wb_en_i,
  input  logic        mem_r_en_i,
  input  logic [31:0] alu_res_i,
  input  logic [31:0] mem_data_i,
  input  logic [3:0]  dest_i,
  output logic        wb_en_o,
  output logic        mem_r_en_o,
  output logic [31:0] alu_res_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  dest_o
);

  logic        wb_en_q;
  logic        mem_r_en_q;
  logic [31:0] alu_res_q;
  logic [31:0] mem_data_q;
  logic [3:0]  dest_q;

  // Bubble clears the enables; load captures the instruction, and the load data only when asked
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      alu_res_q  <= '0;
      mem_data_q <= '0;
      dest_q     <= '0;
    end else if (bubble) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
    end else if (load) begin
      wb_en_q    <= wb_en_i;
      mem_r_en_q <= mem_r_en_i;
      alu_res_q  <= alu_res_i;
      dest_q     <= dest_i;
      if (data_load) begin
        mem_data_q <= mem_data_i;
      end
    end
  end

  assign wb_en_o    = wb_en_q;
  assign mem_r_en_o = mem_r_en_q;
  assign alu_res_o  = alu_res_q;
  assign mem_data_o = mem_data_q;
  assign dest_o     = dest_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage sequencer: bus handshake, pipeline freeze, writeback feed
module mem_stage_ctrl
  import arm_mem_pkg::*;
#(
  parameter int unsigned MEM_BASE = MEM_BASE_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_EN,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [31:0]       ALU_Res,
  input  logic [31:0]       Val_Rm,
  input  logic [3:0]        Dest,
  output logic              freeze,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              WB_EN_out,
  output logic              MEM_R_EN_out,
  output logic [31:0]       ALU_Res_out,
  output logic [31:0]       Mem_data_out,
  output logic [3:0]        Dest_out
);

  mem_state_e        state_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic              access;
  logic              stall;
  logic [31:0]       offset;
  logic [ADDR_W-1:0] addr_d;
  logic              wb_load;
  logic              wb_data_load;
  logic              wb_en_d;

  // A store wins when both request bits are set, so MEM_W_EN alone selects write
  assign access = MEM_R_EN | MEM_W_EN;
  assign offset = ALU_Res - 32'(MEM_BASE);
  // Byte offset to word index; addresses below the base simply wrap
  assign addr_d = ADDR_W'(offset >> 2);

  // Sequencer: start the bus access from IDLE, wait for ack in BUSY, retire in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            we_q    <= MEM_W_EN;
            addr_q  <= addr_d;
            wdata_q <= Val_Rm;
            req_q   <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            if (!we_q) begin
              rdata_q <= mem_rdata;
            end
            req_q   <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Upstream stages hold while an access is starting or outstanding
  assign stall        = ((state_q == IDLE) && access) || (state_q == BUSY);
  assign freeze       = rst & stall;
  assign wb_load      = ((state_q == IDLE) && !access) || (state_q == DONE);
  assign wb_data_load = (state_q == DONE) && !we_q;
  assign wb_en_d      = WB_EN & ~MEM_W_EN;

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  mem_wb_reg u_mem_wb_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (wb_load),
    .bubble     (stall),
    .data_load  (wb_data_load),
    .wb_en_i    (wb_en_d),
    .mem_r_en_i (MEM_R_EN),
    .alu_res_i  (ALU_Res),
    .mem_data_i (rdata_q),
    .dest_i     (Dest),
    .wb_en_o    (WB_EN_out),
    .mem_r_en_o (MEM_R_EN_out),
    .alu_res_o  (ALU_Res_out),
    .mem_data_o (Mem_data_out),
    .dest_o     (Dest_out)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

  logic        clk;
  logic        rst;
  logic        WB_EN, MEM_R_EN, MEM_W_EN;
  logic [31:0] ALU_Res, Val_Rm;
  logic [3:0]  Dest;
  logic        freeze, mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        WB_EN_out, MEM_R_EN_out;
  logic [31:0] ALU_Res_out, Mem_data_out;
  logic [3:0]  Dest_out;

  int passed = 0;
  int total  = 0;

  // Observations gathered while one instruction passes through the stage
  int          obs_cycles, obs_freeze, obs_reqs, obs_busy, obs_wb_cycles;
  logic        obs_freeze_first, obs_stable, obs_bubble_ok, obs_timeout;
  logic [15:0] obs_addr;
  logic        obs_we;
  logic [31:0] obs_wdata;
  logic        obs_wb_en, obs_mr_en;
  logic [31:0] obs_alu, obs_mdata;
  logic [3:0]  obs_dest;

  // Reference state: last loaded memory word seen by the writeback stage
  logic [31:0] model_mdata;

  mem_stage_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .WB_EN        (WB_EN),
    .MEM_R_EN     (MEM_R_EN),
    .MEM_W_EN     (MEM_W_EN),
    .ALU_Res      (ALU_Res),
    .Val_Rm       (Val_Rm),
    .Dest         (Dest),
    .freeze       (freeze),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .WB_EN_out    (WB_EN_out),
    .MEM_R_EN_out (MEM_R_EN_out),
    .ALU_Res_out  (ALU_Res_out),
    .Mem_data_out (Mem_data_out),
    .Dest_out     (Dest_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word index of a byte address relative to a 1024 base, modulo 2^16
  function automatic logic [15:0] word_addr(input logic [31:0] byte_addr);
    longint d;
    d = longint'(byte_addr) - 1024 + (longint'(1) << 40);
    return 16'((d / 4) % 65536);
  endfunction

  // Present one instruction from the EXE/MEM register and act as the memory until it retires
  task automatic issue(input logic we, input logic re, input logic wb, input logic [31:0] alu,
                       input logic [31:0] rm, input logic [3:0] dest, input int wait_n,
                       input logic [31:0] rdata, input logic stray);
    int   busy;
    logic prev_req, last;
    WB_EN = wb; MEM_R_EN = re; MEM_W_EN = we; ALU_Res = alu; Val_Rm = rm; Dest = dest;
    mem_ack = 1'b0; mem_rdata = rdata;
    obs_cycles = 0; obs_freeze = 0; obs_reqs = 0; obs_wb_cycles = 0;
    obs_stable = 1'b1; obs_bubble_ok = 1'b1; obs_timeout = 1'b0;
    obs_addr = '0; obs_we = 1'b0; obs_wdata = '0;
    busy = 0; prev_req = 1'b0;
    #1;
    obs_freeze_first = freeze;
    forever begin
      obs_cycles++;
      if (freeze) obs_freeze++;
      if (WB_EN_out) obs_wb_cycles++;
      if (mem_req && !prev_req) begin
        obs_reqs++; obs_addr = mem_addr; obs_we = mem_we; obs_wdata = mem_wdata;
      end else if (mem_req && (mem_addr !== obs_addr || mem_we !== obs_we || mem_wdata !== obs_wdata)) begin
        obs_stable = 1'b0;
      end
      if (mem_req && (WB_EN_out || MEM_R_EN_out)) obs_bubble_ok = 1'b0;
      if (mem_req) begin
        busy++;
        mem_ack = (busy == wait_n + 1);
      end else begin
        mem_ack = stray && (obs_reqs > 0);
      end
      prev_req = mem_req;
      last = !freeze;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (last) break;
      if (obs_cycles >= 40) begin obs_timeout = 1'b1; break; end
    end
    obs_busy  = busy;
    obs_wb_en = WB_EN_out; obs_mr_en = MEM_R_EN_out; obs_alu = ALU_Res_out;
    obs_mdata = Mem_data_out; obs_dest = Dest_out;
  endtask

  task automatic test_reset();
    rst = 1'b0; WB_EN = 1'b1; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; ALU_Res = 32'd1032;
    Val_Rm = 32'h55; Dest = 4'd1; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (freeze !== 1'b0) $display("FAIL rst_freeze: got %b expected 0", freeze); else passed++;
    total++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b expected 0", mem_req); else passed++;
    total++; if ({mem_we, mem_addr, mem_wdata} !== '0) $display("FAIL rst_bus: got %h expected 0", {mem_we, mem_addr, mem_wdata}); else passed++;
    total++; if ({WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_data_out, Dest_out} !== '0)
      $display("FAIL rst_wb: got %h expected 0", {WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_data_out, Dest_out}); else passed++;
    WB_EN = 1'b0; MEM_R_EN = 1'b0; ALU_Res = '0; Val_Rm = '0; Dest = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b0 || freeze !== 1'b0) $display("FAIL rst_release: got req=%b frz=%b expected 0/0", mem_req, freeze); else passed++;
    model_mdata = '0;
  endtask

  task automatic test_load();
    issue(1'b0, 1'b1, 1'b1, 32'd1032, 32'h0, 4'd5, 0, 32'hDEADBEEF, 1'b0);
    model_mdata = 32'hDEADBEEF;
    total++; if (obs_freeze_first !== 1'b1) $display("FAIL load_freeze_idle: got %b expected 1", obs_freeze_first); else passed++;
    total++; if (obs_addr !== 16'd2 || obs_we !== 1'b0) $display("FAIL load_bus: got addr=%0d we=%b expected 2/0", obs_addr, obs_we); else passed++;
    total++; if (obs_freeze !== 2 || obs_cycles !== 3) $display("FAIL load_timing: got frz=%0d cyc=%0d expected 2/3", obs_freeze, obs_cycles); else passed++;
    total++; if (obs_bubble_ok !== 1'b1) $display("FAIL load_bubble: got %b expected 1", obs_bubble_ok); else passed++;
    total++; if (obs_mdata !== 32'hDEADBEEF || obs_dest !== 4'd5 || obs_wb_en !== 1'b1 || obs_mr_en !== 1'b1)
      $display("FAIL load_wb: got data=%h dest=%0d wb=%b mr=%b expected deadbeef/5/1/1", obs_mdata, obs_dest, obs_wb_en, obs_mr_en); else passed++;
  endtask

  task automatic test_alu();
    issue(1'b0, 1'b0, 1'b1, 32'd7, 32'h0, 4'd3, 0, 32'h0, 1'b0);
    total++; if (obs_reqs !== 0 || obs_freeze !== 0 || obs_cycles !== 1)
      $display("FAIL alu_timing: got req=%0d frz=%0d cyc=%0d expected 0/0/1", obs_reqs, obs_freeze, obs_cycles); else passed++;
    total++; if (obs_alu !== 32'd7 || obs_dest !== 4'd3 || obs_wb_en !== 1'b1)
      $display("FAIL alu_wb: got alu=%0d dest=%0d wb=%b expected 7/3/1", obs_alu, obs_dest, obs_wb_en); else passed++;
    total++; if (obs_mdata !== model_mdata) $display("FAIL alu_mdata_hold: got %h expected %h", obs_mdata, model_mdata); else passed++;
  endtask

  task automatic test_store();
    issue(1'b1, 1'b0, 1'b1, 32'd1024, 32'h12345678, 4'd9, 3, 32'hFFFF0000, 1'b1);
    total++; if (obs_addr !== 16'd0 || obs_we !== 1'b1 || obs_wdata !== 32'h12345678)
      $display("FAIL store_bus: got addr=%0d we=%b data=%h expected 0/1/12345678", obs_addr, obs_we, obs_wdata); else passed++;
    total++; if (obs_stable !== 1'b1 || obs_busy !== 4) $display("FAIL store_hold: got stable=%b busy=%0d expected 1/4", obs_stable, obs_busy); else passed++;
    total++; if (obs_freeze !== 5) $display("FAIL store_freeze: got %0d expected 5", obs_freeze); else passed++;
    total++; if (obs_wb_en !== 1'b0 || obs_mdata !== model_mdata)
      $display("FAIL store_wb: got wb=%b data=%h expected 0/%h", obs_wb_en, obs_mdata, model_mdata); else passed++;
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 1'b1, 1'b1, 32'd1024, 32'h0, 4'd1, 1, 32'hA0A0A0A0, 1'b0);
    total++; if (obs_reqs !== 1 || obs_addr !== 16'd0) $display("FAIL b2b_first: got reqs=%0d addr=%0d expected 1/0", obs_reqs, obs_addr); else passed++;
    total++; if (obs_mdata !== 32'hA0A0A0A0) $display("FAIL b2b_first_data: got %h expected a0a0a0a0", obs_mdata); else passed++;
    issue(1'b0, 1'b1, 1'b1, 32'd1028, 32'h0, 4'd2, 0, 32'hB1B1B1B1, 1'b1);
    total++; if (obs_reqs !== 1 || obs_addr !== 16'd1) $display("FAIL b2b_second: got reqs=%0d addr=%0d expected 1/1", obs_reqs, obs_addr); else passed++;
    total++; if (obs_wb_cycles !== 1 || obs_mdata !== 32'hB1B1B1B1 || obs_dest !== 4'd2)
      $display("FAIL b2b_second_wb: got wbcyc=%0d data=%h dest=%0d expected 1/b1b1b1b1/2", obs_wb_cycles, obs_mdata, obs_dest); else passed++;
    issue(1'b0, 1'b0, 1'b0, 32'd0, 32'h0, 4'd0, 0, 32'h0, 1'b0);
    total++; if (obs_wb_cycles !== 1 || obs_wb_en !== 1'b0) $display("FAIL b2b_once: got wbcyc=%0d wb=%b expected 1/0", obs_wb_cycles, obs_wb_en); else passed++;
    model_mdata = 32'hB1B1B1B1;
  endtask

  task automatic test_reset_busy();
    WB_EN = 1'b1; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; ALU_Res = 32'd1100; Dest = 4'd7;
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b1) $display("FAIL rb_busy: got %b expected 1", mem_req); else passed++;
    #2; rst = 1'b0; #1;
    total++; if ({mem_req, freeze, mem_we, mem_addr, mem_wdata} !== '0)
      $display("FAIL rb_bus_clear: got %h expected 0", {mem_req, freeze, mem_we, mem_addr, mem_wdata}); else passed++;
    total++; if ({WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_data_out, Dest_out} !== '0)
      $display("FAIL rb_wb_clear: got %h expected 0", {WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_data_out, Dest_out}); else passed++;
    WB_EN = 1'b0; MEM_R_EN = 1'b0; ALU_Res = '0; Dest = '0;
    @(posedge clk); #1;
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b0 || Mem_data_out !== 32'd0 || MEM_R_EN_out !== 1'b0 || WB_EN_out !== 1'b0)
      $display("FAIL rb_stray_ack: got req=%b data=%h mr=%b wb=%b expected 0/0/0/0", mem_req, Mem_data_out, MEM_R_EN_out, WB_EN_out); else passed++;
    model_mdata = '0;
    issue(1'b0, 1'b0, 1'b1, 32'd9, 32'h0, 4'd2, 0, 32'h0, 1'b0);
    total++; if (obs_cycles !== 1 || obs_reqs !== 0 || obs_alu !== 32'd9)
      $display("FAIL rb_idle: got cyc=%0d reqs=%0d alu=%0d expected 1/0/9", obs_cycles, obs_reqs, obs_alu); else passed++;
  endtask

  task automatic test_below_base();
    issue(1'b0, 1'b1, 1'b1, 32'd1020, 32'h0, 4'd4, 1, 32'h0BADCAFE, 1'b0);
    model_mdata = 32'h0BADCAFE;
    total++; if (obs_addr !== 16'hFFFF) $display("FAIL below_addr: got %h expected ffff", obs_addr); else passed++;
    total++; if (obs_cycles !== 4 || obs_mdata !== 32'h0BADCAFE)
      $display("FAIL below_done: got cyc=%0d data=%h expected 4/0badcafe", obs_cycles, obs_mdata); else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int          kind, w;
      logic        we, re, wb, stray, acc;
      logic [31:0] alu, rm, rd;
      logic [3:0]  dest;
      kind = int'($urandom_range(0, 2));
      we = (kind == 2); re = (kind == 1); acc = we | re;
      wb = 1'($urandom_range(0, 1)); stray = 1'($urandom_range(0, 1));
      w = int'($urandom_range(0, 3));
      alu = ($urandom_range(0, 3) == 0) ? $urandom : (32'd960 + 32'($urandom_range(0, 1023)));
      rm = $urandom; rd = $urandom; dest = 4'($urandom_range(0, 15));
      issue(we, re, wb, alu, rm, dest, w, rd, stray);
      if (re) model_mdata = rd;
      total++; if (obs_timeout !== 1'b0 || obs_cycles !== (acc ? 3 + w : 1))
        $display("FAIL rnd%0d_cycles: got %0d expected %0d", i, obs_cycles, acc ? 3 + w : 1); else passed++;
      total++; if (obs_freeze !== (acc ? 2 + w : 0)) $display("FAIL rnd%0d_freeze: got %0d expected %0d", i, obs_freeze, acc ? 2 + w : 0); else passed++;
      total++; if (obs_reqs !== (acc ? 1 : 0)) $display("FAIL rnd%0d_reqs: got %0d expected %0d", i, obs_reqs, acc ? 1 : 0); else passed++;
      if (acc) begin
        total++; if (obs_addr !== word_addr(alu) || obs_we !== we || obs_stable !== 1'b1)
          $display("FAIL rnd%0d_bus: got addr=%h we=%b stable=%b expected %h/%b/1", i, obs_addr, obs_we, obs_stable, word_addr(alu), we); else passed++;
        if (we) begin
          total++; if (obs_wdata !== rm) $display("FAIL rnd%0d_wdata: got %h expected %h", i, obs_wdata, rm); else passed++;
        end
      end
      total++; if (obs_wb_en !== (wb & ~we) || obs_mr_en !== re || obs_alu !== alu || obs_dest !== dest)
        $display("FAIL rnd%0d_wb: got wb=%b mr=%b alu=%h dest=%0d expected %b/%b/%h/%0d", i, obs_wb_en, obs_mr_en, obs_alu, obs_dest, wb & ~we, re, alu, dest); else passed++;
      total++; if (obs_mdata !== model_mdata) $display("FAIL rnd%0d_mdata: got %h expected %h", i, obs_mdata, model_mdata); else passed++;
    end
  endtask

  initial begin
    model_mdata = '0;
    test_reset();
    test_load();
    test_alu();
    test_store();
    test_back_to_back();
    test_reset_busy();
    test_below_base();
    test_random();
    WB_EN = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
